// File: rtl/shift_register_pkg.sv
// Shared constants and helpers for the switch-to-LED shift register.
// Latency: n/a (package only).
// Backpressure: n/a.
package shift_register_pkg;

    // System clock frequency; the default tick divider gives one shift per second.
    localparam int unsigned CLK_FREQ_HZ   = 100_000_000;

    // Default register length, one bit per LED.
    localparam int unsigned DEFAULT_WIDTH = 16;

    // Tick counter width: ceil(log2(div)), never below one bit.
    function automatic int unsigned counter_width(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/shift_register_if.sv
// Serial input / parallel output bundle between the switch pad and the LED bank.
// Latency: n/a (wires only).
// Backpressure: none; plain level signals.
//   serial_in    : switch level, driven by the master, asynchronous to the clock
//   parallel_out : register contents, driven by the slave (bit 0 newest)
interface shift_register_if
    import shift_register_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             serial_in;
    logic [WIDTH-1:0] parallel_out;

    modport master (output serial_in, input  parallel_out);
    modport slave  (input  serial_in, output parallel_out);
endinterface

// File: rtl/shift_register_tick_generator.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// Latency: first tick TICK_DIV-1 cycles after reset release (shift lands on edge TICK_DIV).
// Backpressure: none; free-running.
//   clk_100MHz : system clock
//   reset_n    : asynchronous active-low reset, clears the count
//   tick       : high for the single cycle in which the count equals TICK_DIV-1
module tick_generator
    import shift_register_pkg::*;
#(
    parameter int unsigned TICK_DIV = CLK_FREQ_HZ
) (
    input  logic clk_100MHz,
    input  logic reset_n,
    output logic tick
);
    localparam int unsigned    CW   = counter_width(TICK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decoded straight from the count flop; TICK_DIV >= 2 rules out back-to-back ticks.
    assign tick = (cnt_q == LAST);
endmodule

// File: rtl/shift_register.sv
// Serial-in parallel-out register: synchronised switch bit shifted in once per tick.
// Latency: serial_in reaches the sync stage after SYNC_STAGES cycles, enters the register on the next tick.
// Backpressure: none; input sampled only on ticks, changes between ticks are dropped.
//   clk_100MHz   : system clock
//   reset_n      : asynchronous active-low reset (register, counter and synchroniser cleared)
//   sr.serial_in : asynchronous switch level
//   sr.parallel_out : register contents, bit 0 newest, bit WIDTH-1 oldest, driven from flops
module shift_register
    import shift_register_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned TICK_DIV    = CLK_FREQ_HZ,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk_100MHz,
    input  logic           reset_n,
    shift_register_if.slave sr
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;
    logic                   tick;
    logic [WIDTH-1:0]       shift_q;
    logic [WIDTH-1:0]       shift_d;

    tick_generator #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .tick       (tick)
    );

    // Metastability chain; bit 0 sees the raw pad level.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sr.serial_in};
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    // Oldest bit falls off the top; newest enters at bit 0.
    always_comb begin
        shift_d = tick ? {shift_q[WIDTH-2:0], sync_in} : shift_q;
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign sr.parallel_out = shift_q;
endmodule

// File: tb/tb_shift_register.sv
// Self-checking bench for shift_register with a small tick divider.
// Latency: n/a.
// Backpressure: n/a.
module tb_shift_register;
    import shift_register_pkg::*;

    localparam int W   = 16;
    localparam int DIV = 10;
    localparam int SS  = 2;

    logic clk_100MHz = 1'b0;
    logic reset_n    = 1'b1;

    shift_register_if #(.WIDTH(W)) sr ();

    shift_register #(
        .WIDTH       (W),
        .TICK_DIV    (DIV),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .sr         (sr)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int errors = 0;
    int checks = 0;

    // Reference model: edges since release, a plain delay line for the
    // synchroniser latency, and the expected LED word.
    logic [W-1:0] m_out;
    int           m_cnt;
    bit           m_pipe[$];

    typedef struct {
        logic         in;
        int           cycles;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl[4];

    task automatic model_reset();
        m_out  = '0;
        m_cnt  = 0;
        m_pipe = {};
        for (int i = 0; i < SS; i++) m_pipe.push_back(1'b0);
    endtask

    task automatic model_edge();
        bit cap;
        if (!reset_n) begin
            model_reset();
        end else begin
            m_cnt++;
            cap = m_pipe.pop_front();
            m_pipe.push_back(sr.serial_in);
            if (m_cnt % DIV == 0) m_out = {m_out[W-2:0], cap};
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // One or more clock edges; every cycle the output and the tick are checked
    // against the model, so any change off a tick edge is caught.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_100MHz);
            model_edge();
            #1;
            check("out_vs_model", {16'h0, sr.parallel_out}, {16'h0, m_out});
            check("tick_vs_model", {31'h0, dut.u_tick.tick},
                  {31'h0, (reset_n && (m_cnt % DIV == DIV - 1))});
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        model_reset();
        step(2);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{in: 1'b1, cycles: 25, exp: 16'h0003};
        tbl[1] = '{in: 1'b0, cycles: 20, exp: 16'h000C};
        tbl[2] = '{in: 1'b1, cycles: 40, exp: 16'h00CF};
        tbl[3] = '{in: 1'b0, cycles: 15, exp: 16'h033C};

        // Reset: immediate clear, held three cycles with serial_in high.
        sr.serial_in = 1'b1;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("reset_immediate", {16'h0, sr.parallel_out}, 32'h0);
        step(3);
        check("reset_held", {16'h0, sr.parallel_out}, 32'h0);
        reset_n = 1'b1;
        step(9);
        check("before_first_tick", {16'h0, sr.parallel_out}, 32'h0);
        step(1);
        check("first_tick", {16'h0, sr.parallel_out}, 32'h1);

        // Segment pattern from the table.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            sr.serial_in = tbl[i].in;
            step(tbl[i].cycles);
            check($sformatf("pattern_seg%0d", i), {16'h0, sr.parallel_out}, {16'h0, tbl[i].exp});
        end

        // Saturation and MSB drop.
        apply_reset();
        sr.serial_in = 1'b1;
        step(159);
        check("sat_tick15", {16'h0, sr.parallel_out}, 32'h7FFF);
        step(1);
        check("sat_tick16", {16'h0, sr.parallel_out}, 32'hFFFF);
        step(40);
        check("sat_tick20", {16'h0, sr.parallel_out}, 32'hFFFF);
        sr.serial_in = 1'b0;
        step(10);
        check("sat_msb_drop", {16'h0, sr.parallel_out}, 32'hFFFE);

        // Glitch between ticks is never sampled.
        apply_reset();
        sr.serial_in = 1'b0;
        step(11);
        sr.serial_in = 1'b1;
        step(3);
        sr.serial_in = 1'b0;
        step(20);
        check("glitch_rejected", {16'h0, sr.parallel_out}, 32'h0);

        // Asynchronous reset in the middle of a cycle.
        apply_reset();
        sr.serial_in = 1'b1;
        step(80);
        check("pre_async_ff", {16'h0, sr.parallel_out}, 32'h00FF);
        step(4);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_clear", {16'h0, sr.parallel_out}, 32'h0);
        step(2);
        reset_n = 1'b1;
        step(9);
        check("async_no_early_tick", {16'h0, sr.parallel_out}, 32'h0);
        step(1);
        check("async_retick", {16'h0, sr.parallel_out}, 32'h1);

        // Random switch activity against the model.
        apply_reset();
        sr.serial_in = 1'($urandom_range(0, 1));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) sr.serial_in = ~sr.serial_in;
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shift_register.md
Name: shift_register

Overview:
- Serial-in, parallel-out shift register for a board switch driving 16 LEDs.
- The slide switch level on serial_in is synchronised to clk_100MHz.
- On every shift tick (default 1 Hz, derived from the 100 MHz clock) the synchronised bit enters the register and all bits move one place.
- Sits directly between the switch input pad and the LED output bank.

Parameters:
- WIDTH, 16, number of register bits / LEDs.
- TICK_DIV, 100_000_000, clk_100MHz cycles per shift tick (1 s at 100 MHz); legal range >= 2.
- SYNC_STAGES, 2, flip-flop stages in the serial_in synchroniser; legal range >= 2.

Ports:
- clk_100MHz  input  1  system clock, 100 MHz, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- serial_in  input  1  asynchronous switch level, the bit to shift in.
- parallel_out  output  WIDTH  register contents; bit 0 is the newest bit, bit WIDTH-1 the oldest.

Behaviour:
- Clocking and reset: one clock (clk_100MHz); reset is asynchronous and active-low (reset_n).
- While reset_n = 0:
  - parallel_out = 0;
  - tick counter = 0;
  - all synchroniser flops = 0.
- Reset assertion takes effect immediately, without waiting for a clock edge; release is sampled on the next rising edge.
- Reset mid-operation discards the partial tick count and the register contents.
- Synchroniser: serial_in passes through a SYNC_STAGES flop chain; the last stage is sync_in.
  - Latency from serial_in to sync_in is SYNC_STAGES cycles.
  - No debounce is required; the 1 s sampling makes bounce irrelevant.
- Tick generator: counter runs 0..TICK_DIV-1, increments every cycle, and wraps to 0.
  - tick = 1 for exactly one cycle when counter == TICK_DIV-1.
  - First tick after reset release occurs in cycle TICK_DIV; thereafter one tick every TICK_DIV cycles, never two consecutive.
  - Counter width is ceil(log2(TICK_DIV)) bits, so there is no overflow at the default value.
- Shift: on a rising edge with tick = 1, parallel_out <= {parallel_out[WIDTH-2:0], sync_in}.
  - The oldest bit (MSB) is discarded.
  - Without tick, parallel_out holds.
- parallel_out is driven directly from flops: no combinational path from serial_in.
- A serial_in change shorter than one tick period that falls between ticks is never captured. This is intended sampling behaviour.
- After WIDTH ticks of a constant input c, parallel_out is all-c, and it stays there while the input is unchanged.

Decomposition:
- Package shift_register_pkg holds:
  - constant CLK_FREQ_HZ = 100_000_000;
  - default WIDTH = 16;
  - the function computing the counter width from TICK_DIV.
- One sub-module, tick_generator (parameter TICK_DIV; ports clk_100MHz, reset_n, tick), produces the one-cycle tick pulse.
- The synchroniser and the shift register stay in the top level.

Test Plan:
- Run all scenarios with TICK_DIV = 10 and SYNC_STAGES = 2, clock period 10 ns.
- Reset: hold reset_n = 0 for 3 cycles with serial_in = 1 -> parallel_out = 0x0000 throughout; after release the first change is at cycle 10 and gives 0x0001.
- Pattern: after reset, hold serial_in = 1 for 25 cycles, 0 for 20, 1 for 40, 0 for 15 -> after the 10th tick parallel_out = 0x033C (bit sequence 1,1,0,0,1,1,1,1,0,0).
- Saturation/overflow: serial_in = 1 for 20 ticks -> 0xFFFF from tick 16 onward; then serial_in = 0 for 1 tick -> 0xFFFE (MSB dropped).
- Tick spacing: monitor the internal tick -> exactly one 1-cycle pulse every 10 cycles, and parallel_out changes only on those edges.
- Glitch rejection: a 3-cycle serial_in = 1 pulse placed entirely between two ticks, with serial_in = 0 otherwise -> parallel_out stays 0x0000.
- Async reset mid-run: assert reset_n = 0 mid-cycle while parallel_out = 0x00FF -> parallel_out = 0x0000 before the next clock edge; after release the next tick is again 10 cycles later.
